// File: rtl/cache_help.sv
// Shared line-protocol types for the L2 cache and the main-memory responder below it.
package cache_help;

  localparam int MEMORY_LINE_ADDRESS_WIDTH = 23;
  localparam int LINE_WIDTH                = 100;
  localparam int MAIN_MEMORY_LATENCY       = 8;

  typedef logic [MEMORY_LINE_ADDRESS_WIDTH-1:0] MemoryLineAddress;
  typedef logic [LINE_WIDTH-1:0]                Line;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } MemoryOperation;

  typedef struct packed {
    MemoryOperation   op;
    MemoryLineAddress line_address;
    Line              data;
  } MainMemoryRequest;

  typedef struct packed {
    MemoryOperation   op;
    MemoryLineAddress line_address;
    Line              data;
  } MainMemoryResponse;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } responder_state_e;

endpackage

// File: rtl/main_memory_responder_line_memory.sv
// Single-port line RAM with a registered read; contents are never reset.
module line_memory #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 100
) (
  input  logic                     clk_in,
  input  logic                     enable_in,
  input  logic                     write_enable_in,
  input  logic [$clog2(DEPTH)-1:0] index_in,
  input  logic [WIDTH-1:0]         write_data_in,
  output logic [WIDTH-1:0]         read_data_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] read_data_q;

  always_ff @(posedge clk_in) begin
    if (enable_in) begin
      if (write_enable_in) begin
        mem_q[index_in] <= write_data_in;
      end else begin
        read_data_q <= mem_q[index_in];
      end
    end
  end

  assign read_data_out = read_data_q;

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency off-chip memory stand-in: one outstanding line LOAD/STORE at a time.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
module main_memory_responder
  import cache_help::*;
#(
  parameter int LATENCY    = MAIN_MEMORY_LATENCY,
  parameter int INDEX_BITS = 10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  MemoryOperation   req_op_in,
  input  MemoryLineAddress req_line_address_in,
  input  Line              req_data_in,
  output logic             resp_valid_out,
  input  logic             resp_ready_in,
  output MemoryOperation   resp_op_out,
  output MemoryLineAddress resp_line_address_out,
  output Line              resp_data_out
);

  responder_state_e  state_q;
  logic [7:0]        count_q;
  MainMemoryRequest  req_q;
  MainMemoryResponse resp_q;
  logic              resp_valid_q;
  logic              req_ready_q;
  logic              load_sel_q;

  logic                  ram_enable;
  logic                  ram_write_enable;
  logic [INDEX_BITS-1:0] ram_index;
  Line                   ram_read_data;

  // Access fires in the last WAIT cycle; reset in that cycle suppresses a pending write.
  assign ram_enable       = (state_q == WAIT) && (count_q == 8'd1) && !rst_in;
  assign ram_write_enable = (req_q.op == STORE);
  assign ram_index        = req_q.line_address[INDEX_BITS-1:0];

  line_memory #(
    .DEPTH(2 ** INDEX_BITS),
    .WIDTH(LINE_WIDTH)
  ) u_line_memory (
    .clk_in         (clk_in),
    .enable_in      (ram_enable),
    .write_enable_in(ram_write_enable),
    .index_in       (ram_index),
    .write_data_in  (req_q.data),
    .read_data_out  (ram_read_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      req_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      load_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_in && req_ready_q) begin
            req_q.op           <= req_op_in;
            req_q.line_address <= req_line_address_in;
            req_q.data         <= req_data_in;
            count_q            <= 8'(LATENCY - 1);
            req_ready_q        <= 1'b0;
            state_q            <= WAIT;
          end
        end
        WAIT: begin
          count_q <= count_q - 8'd1;
          if (count_q == 8'd1) begin
            resp_q       <= req_q;
            // LOAD data comes straight from the RAM output register, which holds until the next access.
            load_sel_q   <= (req_q.op == LOAD);
            resp_valid_q <= 1'b1;
            state_q      <= RESPOND;
          end
        end
        RESPOND: begin
          if (resp_valid_q && resp_ready_in) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_out         = req_ready_q;
  assign resp_valid_out        = resp_valid_q;
  assign resp_op_out           = resp_q.op;
  assign resp_line_address_out = resp_q.line_address;
  assign resp_data_out         = load_sel_q ? ram_read_data : resp_q.data;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, backpressure, aliasing, reset, random pairs.
module tb_main_memory_responder;
  import cache_help::*;

  localparam int LAT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready_out;
  MemoryOperation   req_op;
  MemoryLineAddress req_addr;
  Line              req_data;
  logic             resp_valid_out;
  logic             resp_ready;
  MemoryOperation   resp_op_out;
  MemoryLineAddress resp_line_address_out;
  Line              resp_data_out;

  int checks   = 0;
  int failures = 0;
  int n_req    = 0;
  int n_resp   = 0;
  logic [123:0] exp_q[$];

  always #5 clk = ~clk;

  main_memory_responder #(
    .LATENCY   (LAT),
    .INDEX_BITS(10)
  ) dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .req_valid_in         (req_valid),
    .req_ready_out        (req_ready_out),
    .req_op_in            (req_op),
    .req_line_address_in  (req_addr),
    .req_data_in          (req_data),
    .resp_valid_out       (resp_valid_out),
    .resp_ready_in        (resp_ready),
    .resp_op_out          (resp_op_out),
    .resp_line_address_out(resp_line_address_out),
    .resp_data_out        (resp_data_out)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input MemoryOperation op, input MemoryLineAddress a, input Line d);
    int n = 0;
    while (!req_ready_out && n < 100) begin
      step();
      n++;
    end
    chk("req_ready_wait", req_ready_out, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
    n_req++;
  endtask

  task automatic get_resp(input string tag);
    int n = 0;
    logic [123:0] e;
    resp_ready = 1'b1;
    while (!resp_valid_out && n < LAT + 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, resp_valid_out, 1);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_op"}, resp_op_out, e[123]);
    chk({tag, "_addr"}, resp_line_address_out, e[122:100]);
    chk({tag, "_data"}, resp_data_out, e[99:0]);
    if (resp_valid_out) n_resp++;
    step();
    chk({tag, "_drop"}, resp_valid_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Line d1, da, de, df, d9, rd;
    logic [127:0] r;
    logic [123:0] pk;
    Line mdl [int];
    int idx_list[$];

    d1 = 100'h0ABC_DEF0_1234_5678_9ABC_D0123;
    da = 100'h5_5555_AAAA_5555_AAAA_5555_AAAA;
    de = 100'hE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
    df = 100'hF_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    d9 = 100'h9_9999_9999_9999_9999_9999_9999;

    // clock/reset
    rst = 1'b1; req_valid = 1'b0; req_op = LOAD; req_addr = '0; req_data = '0; resp_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    chk("rst_req_ready", req_ready_out, 1);
    chk("rst_resp_valid", resp_valid_out, 0);
    chk("rst_resp_op", resp_op_out, 0);
    chk("rst_resp_addr", resp_line_address_out, 0);
    chk("rst_resp_data", resp_data_out, 0);

    // store then load same line
    send(STORE, 23'h000005, d1); exp_q.push_back({STORE, 23'h000005, d1}); get_resp("st5");
    send(LOAD, 23'h000005, '0);  exp_q.push_back({LOAD, 23'h000005, d1});  get_resp("ld5");

    // latency profile: accept ends cycle T, now in T+1
    send(LOAD, 23'h000005, '0);
    pk = {LOAD, 23'h000005, d1};
    for (int k = 1; k <= LAT + 1; k++) begin
      chk("lat_req_ready", req_ready_out, (k == LAT + 1));
      chk("lat_resp_valid", resp_valid_out, (k == LAT));
      if (k == LAT) begin
        chk("lat_op", resp_op_out, pk[123]);
        chk("lat_addr", resp_line_address_out, pk[122:100]);
        chk("lat_data", resp_data_out, pk[99:0]);
        n_resp++;
      end
      step();
    end

    // backpressure with a request offered during the stall
    resp_ready = 1'b0;
    send(LOAD, 23'h000005, '0);
    for (int n = 0; n < LAT + 20 && !resp_valid_out; n++) step();
    for (int c = 0; c < 20; c++) begin
      req_valid = 1'b1; req_op = STORE; req_addr = 23'h000009; req_data = d9;
      chk("bp_valid", resp_valid_out, 1);
      chk("bp_req_ready", req_ready_out, 0);
      chk("bp_op", resp_op_out, LOAD);
      chk("bp_addr", resp_line_address_out, 23'h000005);
      chk("bp_data", resp_data_out, d1);
      step();
    end
    req_valid = 1'b0;
    exp_q.push_back({LOAD, 23'h000005, d1});
    get_resp("bp_release");
    for (int c = 0; c < LAT + 3; c++) begin
      chk("bp_no_extra_resp", resp_valid_out, 0);
      step();
    end

    // aliasing modulo 1024 lines
    send(STORE, 23'h000403, da); exp_q.push_back({STORE, 23'h000403, da}); get_resp("alias_st");
    send(LOAD, 23'h000003, '0);  exp_q.push_back({LOAD, 23'h000003, da});  get_resp("alias_ld");

    // reset during WAIT drops a pending STORE
    send(STORE, 23'h000007, df); exp_q.push_back({STORE, 23'h000007, df}); get_resp("f_st");
    send(STORE, 23'h000007, de);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wrst_req_ready", req_ready_out, 1);
    chk("wrst_resp_valid", resp_valid_out, 0);
    chk("wrst_resp_data", resp_data_out, 0);
    for (int c = 0; c < LAT + 3; c++) begin
      chk("wrst_no_resp", resp_valid_out, 0);
      step();
    end
    send(LOAD, 23'h000007, '0); exp_q.push_back({LOAD, 23'h000007, df}); get_resp("wrst_ld");

    // random store/load pairs against a line model
    for (int i = 0; i < 16; i++) begin
      int idx, j, lidx;
      MemoryLineAddress a;
      idx = $urandom_range(0, 1023);
      r = {$urandom, $urandom, $urandom, $urandom};
      rd = r[99:0];
      a = {13'($urandom_range(0, 8191)), 10'(idx)};
      send(STORE, a, rd); exp_q.push_back({STORE, a, rd}); get_resp("rnd_st");
      mdl[idx] = rd;
      idx_list.push_back(idx);
      j = $urandom_range(0, idx_list.size() - 1);
      lidx = idx_list[j];
      a = {13'($urandom_range(0, 8191)), 10'(lidx)};
      send(LOAD, a, '0); exp_q.push_back({LOAD, a, mdl[lidx]}); get_resp("rnd_ld");
    end

    // one response per accepted request, except the one dropped by reset
    chk("resp_count", n_resp, n_req - 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
